// File: rtl/mips_hazard_pkg.sv
// Shared types for the MIPS pipeline hazard controller.
// Stage control bundles, hazard source tags, register index type.
package mips_hazard_pkg;

   typedef logic [4:0] reg_idx_t;

   typedef struct packed {
      logic en;
      logic flush;
   } pipe_ctrl_t;

   typedef enum logic [2:0] {
      HZ_NONE,
      HZ_MEM,
      HZ_BRANCH,
      HZ_LOADUSE,
      HZ_HILO
   } hazard_src_t;

   localparam pipe_ctrl_t CTRL_RUN    = '{en: 1'b1, flush: 1'b0};
   localparam pipe_ctrl_t CTRL_HOLD   = '{en: 1'b0, flush: 1'b0};
   localparam pipe_ctrl_t CTRL_BUBBLE = '{en: 1'b1, flush: 1'b1};
   localparam pipe_ctrl_t CTRL_KILL   = '{en: 1'b0, flush: 1'b1};

   function automatic logic reg_hit(
      input logic     uses,
      input reg_idx_t src,
      input reg_idx_t dst
   );
      return uses && (src == dst);
   endfunction

endpackage

// File: rtl/md_busy_counter.sv
// HI/LO unit occupancy countdown.
// Loads (latency-1) on an accepted start, then counts down to zero.
module md_busy_counter
   import mips_hazard_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_div,
   input  logic             hold_start,
   output logic             busy,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (start && !hold_start) begin
         cnt <= is_div ? DIV_LD : MUL_LD;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush generator for the 5-stage MIPS pipeline.
// Define HAZARD_PERF_EN to add stall_cycles/flush_events counters.
module hazard_ctrl
   import mips_hazard_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
   input  logic        clk,
   input  logic        reset,
   input  reg_idx_t    id_rs,
   input  reg_idx_t    id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic        id_uses_hilo,
   input  logic        ex_mem_read,
   input  reg_idx_t    ex_rt,
   input  logic        ex_branch_taken,
   input  logic        ex_md_start,
   input  logic        ex_md_is_div,
   input  logic        dmem_wait,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idex_en,
   output logic        idex_flush,
   output logic        exmem_en,
   output logic        exmem_flush,
   output logic        memwb_en,
   output logic        memwb_flush,
   output logic        md_busy
`ifdef HAZARD_PERF_EN
  ,output logic [31:0] stall_cycles,
   output logic [31:0] flush_events
`endif
);

   logic [CNT_W-1:0] md_cnt;
   logic             load_use;
   logic             hilo_stall;
   logic             hz_mem;
   logic             hz_br;
   logic             hz_lu;
   logic             hz_hl;
   hazard_src_t      src;
   pipe_ctrl_t       ifid;
   pipe_ctrl_t       idex;
   pipe_ctrl_t       exmem;
   pipe_ctrl_t       memwb;

   md_busy_counter #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES),
      .CNT_W      (CNT_W)
   ) u_md_cnt (
      .clk        (clk),
      .reset      (reset),
      .start      (ex_md_start),
      .is_div     (ex_md_is_div),
      .hold_start (dmem_wait),
      .busy       (md_busy),
      .cnt        (md_cnt)
   );

   assign load_use = ex_mem_read && (ex_rt != '0) &&
                     (reg_hit(id_uses_rs, id_rs, ex_rt) ||
                      reg_hit(id_uses_rt, id_rt, ex_rt));

   // an op issuing this cycle blocks a HI/LO reader before md_cnt loads
   assign hilo_stall = id_uses_hilo &&
                       (md_busy || (ex_md_start && !dmem_wait));

   assign hz_mem = dmem_wait;
   assign hz_br  = ex_branch_taken && !hz_mem;
   assign hz_lu  = load_use && !hz_mem && !ex_branch_taken;
   assign hz_hl  = hilo_stall && !hz_mem && !ex_branch_taken &&
                   !load_use;

   always_comb begin
      src = HZ_NONE;
      unique case (1'b1)
         hz_mem:  src = HZ_MEM;
         hz_br:   src = HZ_BRANCH;
         hz_lu:   src = HZ_LOADUSE;
         hz_hl:   src = HZ_HILO;
         default: src = HZ_NONE;
      endcase
   end

   always_comb begin
      pc_en = 1'b1;
      ifid  = CTRL_RUN;
      idex  = CTRL_RUN;
      exmem = CTRL_RUN;
      memwb = CTRL_RUN;
      if (reset) begin
         pc_en = 1'b0;
         ifid  = CTRL_KILL;
         idex  = CTRL_KILL;
         exmem = CTRL_KILL;
         memwb = CTRL_KILL;
      end else begin
         unique case (src)
            HZ_MEM: begin
               pc_en = 1'b0;
               ifid  = CTRL_HOLD;
               idex  = CTRL_HOLD;
               exmem = CTRL_HOLD;
               memwb = CTRL_BUBBLE;
            end
            HZ_BRANCH: begin
               ifid = CTRL_BUBBLE;
               idex = CTRL_BUBBLE;
            end
            HZ_LOADUSE, HZ_HILO: begin
               pc_en = 1'b0;
               ifid  = CTRL_HOLD;
               idex  = CTRL_BUBBLE;
            end
            default: ;
         endcase
      end
   end

   assign ifid_en     = ifid.en;
   assign ifid_flush  = ifid.flush;
   assign idex_en     = idex.en;
   assign idex_flush  = idex.flush;
   assign exmem_en    = exmem.en;
   assign exmem_flush = exmem.flush;
   assign memwb_en    = memwb.en;
   assign memwb_flush = memwb.flush;

   // a second HI/LO op can only issue once the previous one drained
   always_ff @(posedge clk) begin
      if (!reset && ex_md_start && !dmem_wait)
         assert (md_cnt == '0);
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (!pc_en && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
         if (ifid_flush && (flush_events != '1))
            flush_events <= flush_events + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl.
// Control word order: pc, ifid en/fl, idex en/fl, exmem en/fl, memwb en/fl.
module tb_hazard_ctrl;

   logic       clk;
   logic       reset;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_uses_rs;
   logic       id_uses_rt;
   logic       id_uses_hilo;
   logic       ex_mem_read;
   logic [4:0] ex_rt;
   logic       ex_branch_taken;
   logic       ex_md_start;
   logic       ex_md_is_div;
   logic       dmem_wait;
   logic       pc_en;
   logic       ifid_en;
   logic       ifid_flush;
   logic       idex_en;
   logic       idex_flush;
   logic       exmem_en;
   logic       exmem_flush;
   logic       memwb_en;
   logic       memwb_flush;
   logic       md_busy;
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_events;
`endif

   logic [8:0] ctl;
   int         n_vec;
   int         n_err;
   int         stalls;

   localparam logic [8:0] C_NONE  = 9'b1_10_10_10_10;
   localparam logic [8:0] C_RST   = 9'b0_01_01_01_01;
   localparam logic [8:0] C_MEM   = 9'b0_00_00_00_11;
   localparam logic [8:0] C_BR    = 9'b1_11_11_10_10;
   localparam logic [8:0] C_STALL = 9'b0_00_11_10_10;

   hazard_ctrl #(
      .MUL_CYCLES (4),
      .DIV_CYCLES (32)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rs      (id_uses_rs),
      .id_uses_rt      (id_uses_rt),
      .id_uses_hilo    (id_uses_hilo),
      .ex_mem_read     (ex_mem_read),
      .ex_rt           (ex_rt),
      .ex_branch_taken (ex_branch_taken),
      .ex_md_start     (ex_md_start),
      .ex_md_is_div    (ex_md_is_div),
      .dmem_wait       (dmem_wait),
      .pc_en           (pc_en),
      .ifid_en         (ifid_en),
      .ifid_flush      (ifid_flush),
      .idex_en         (idex_en),
      .idex_flush      (idex_flush),
      .exmem_en        (exmem_en),
      .exmem_flush     (exmem_flush),
      .memwb_en        (memwb_en),
      .memwb_flush     (memwb_flush),
      .md_busy         (md_busy)
`ifdef HAZARD_PERF_EN
     ,.stall_cycles    (stall_cycles),
      .flush_events    (flush_events)
`endif
   );

   assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                 exmem_en, exmem_flush, memwb_en, memwb_flush};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs           = 5'd0;
      id_rt           = 5'd0;
      id_uses_rs      = 1'b0;
      id_uses_rt      = 1'b0;
      id_uses_hilo    = 1'b0;
      ex_mem_read     = 1'b0;
      ex_rt           = 5'd0;
      ex_branch_taken = 1'b0;
      ex_md_start     = 1'b0;
      ex_md_is_div    = 1'b0;
      dmem_wait       = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      idle();
      reset = 1'b1;
      @(negedge clk);
      chk("rst_ctl", ctl, C_RST);
      tick();
      @(negedge clk);
      chk("rst_busy", md_busy, 0);
      reset = 1'b0;
      tick();
      @(negedge clk);
      chk("idle_ctl", ctl, C_NONE);
      tick();

      // load-use on rs: one stall cycle, then clear
      ex_mem_read = 1'b1; ex_rt = 5'd8;
      id_rs = 5'd8; id_uses_rs = 1'b1;
      @(negedge clk);
      chk("lu_rs", ctl, C_STALL);
      tick();
      ex_mem_read = 1'b0;
      @(negedge clk);
      chk("lu_after", ctl, C_NONE);
      tick();

      ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
      @(negedge clk);
      chk("lu_r0", ctl, C_NONE);
      tick();

      ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b1;
      @(negedge clk);
      chk("lu_rt", ctl, C_STALL);
      tick();
      id_uses_rt = 1'b0;
      @(negedge clk);
      chk("lu_rt_unused", ctl, C_NONE);
      tick();

      // branch beats load-use
      id_uses_rt = 1'b1; ex_branch_taken = 1'b1;
      @(negedge clk);
      chk("br_vs_lu", ctl, C_BR);
      tick();

      // dmem_wait beats branch for 3 cycles
      dmem_wait = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mem_hold", ctl, C_MEM);
         tick();
      end
      dmem_wait = 1'b0;
      @(negedge clk);
      chk("mem_then_br", ctl, C_BR);
      tick();
      idle();
      @(negedge clk);
      chk("br_done", ctl, C_NONE);
      tick();

      // div then mflo: 32 stall cycles from a clean reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      ex_md_start = 1'b1; ex_md_is_div = 1'b1; id_uses_hilo = 1'b1;
      stalls = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ctl != C_STALL) break;
         stalls++;
         if (i == 1) chk("div_busy", md_busy, 1);
         tick();
         ex_md_start = 1'b0; ex_md_is_div = 1'b0;
      end
      chk("div_stalls", stalls, 32);
      chk("div_release", ctl, C_NONE);
      chk("div_idle", md_busy, 0);
`ifdef HAZARD_PERF_EN
      chk("perf_stall", stall_cycles, 32);
      chk("perf_flush", flush_events, 0);
`endif
      tick();

      // mult held off by dmem_wait, then 4 stall cycles
      ex_md_start = 1'b1; dmem_wait = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("mul_mem", ctl, C_MEM);
         tick();
      end
      chk("mul_held", md_busy, 0);
      dmem_wait = 1'b0;
      stalls = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ctl != C_STALL) break;
         stalls++;
         tick();
         ex_md_start = 1'b0;
      end
      chk("mul_stalls", stalls, 4);
      tick();

      // reset mid-divide at md_cnt=17
      idle();
      ex_md_start = 1'b1; ex_md_is_div = 1'b1;
      @(negedge clk);
      chk("div_nohilo", ctl, C_NONE);
      tick();
      idle();
      for (int i = 0; i < 14; i++) tick();
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_ctl", ctl, C_RST);
      chk("mid_rst_busy", md_busy, 1);
      tick();
      reset = 1'b0;
      id_uses_hilo = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", md_busy, 0);
      chk("post_rst_ctl", ctl, C_NONE);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
